time_set_writer: RTL and testbench

// - Drives the set/load side of the stopwatch digit counters. It is the writer that feeds value/set/legal into each 0-5 or 0-9 digit counter.
// - Walks the operator through the digits one at a time from button levels, then issues one load strobe per digit.
// - Sits between the debounced button block and the four digit counters (sec units, sec tens, min units, min tens).
// - Only operates in watch mode (sel_Stopwatch_Watch=0).

---
 rtl/time_set_writer_if.sv | 24 ++
 rtl/time_set_writer.sv | 151 +++++++++++++++
 tb/tb_time_set_writer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_writer_if.sv
// Load bus between the time-set writer and the four stopwatch digit counters.
// The writer drives value/set/legal and reads back the live digit values.
interface time_set_writer_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]              value;
    logic [NUM_DIGITS-1:0]   set;
    logic                    legal;
    logic [4*NUM_DIGITS-1:0] cur_digit;

    modport master (
        output value,
        output set,
        output legal,
        input  cur_digit
    );

    modport slave (
        input  value,
        input  set,
        input  legal,
        output cur_digit
    );
endinterface

// File: rtl/time_set_writer.sv
// Time-set writer: walks the operator through the digit counters one at a
// time using debounced button levels, then loads each edited digit with a
// single one-cycle strobe. Held idle whenever stopwatch mode is selected.
module time_set_writer #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_UNITS  = 9,
    parameter int MAX_TENS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel_Stopwatch_Watch,
    input  logic                  btn_enter,
    input  logic                  btn_inc,
    input  logic                  btn_next,
    input  logic                  btn_abort,
    time_set_writer_if.master     bus,
    output logic [NUM_DIGITS-1:0] edit_digit,
    output logic                  busy,
    output logic                  done
);

    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]      MAX_U    = 4'(MAX_UNITS);
    localparam logic [3:0]      MAX_T    = 4'(MAX_TENS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Button bit positions inside the edge-detect vectors
    localparam int B_ENTER = 0;
    localparam int B_INC   = 1;
    localparam int B_NEXT  = 2;
    localparam int B_ABORT = 3;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        LOAD,
        ADVANCE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       edit_q, edit_d;
    logic [3:0]       btn_curr_q, btn_curr_d;
    logic [3:0]       btn_prev_q, btn_prev_d;

    logic [3:0]       btn_edge;
    logic [IDX_W-1:0] load_idx;
    logic [3:0]       load_raw;
    logic [3:0]       load_max;
    logic [3:0]       load_val;
    logic [3:0]       edit_max;
    logic             mode_block;

    // Stopwatch mode forces the writer out of any session, including
    // swallowing a load strobe that would otherwise go out this cycle.
    assign mode_block = sel_Stopwatch_Watch;

    // Register each button once and keep the previous sample for edges
    always_comb begin
        btn_curr_d = {btn_abort, btn_next, btn_inc, btn_enter};
        btn_prev_d = btn_curr_q;
        btn_edge   = btn_curr_q & ~btn_prev_q;
    end

    // Fetch the live value of the digit about to be edited, clamped to its range
    always_comb begin
        load_idx = (state_q == ADVANCE) ? (idx_q + IDX_W'(1)) : '0;
        load_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_idx == IDX_W'(i)) begin
                load_raw = bus.cur_digit[4*i +: 4];
            end
        end
        load_max = load_idx[0] ? MAX_T : MAX_U;
        load_val = (load_raw > load_max) ? 4'd0 : load_raw;
        edit_max = idx_q[0] ? MAX_T : MAX_U;
    end

    // Session FSM: next state, edit register updates and bus outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        edit_d     = edit_q;
        bus.set    = '0;
        bus.value  = edit_q;
        bus.legal  = 1'b0;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        edit_digit = (state_q != IDLE) ? (NUM_DIGITS'(1) << idx_q) : '0;

        case (state_q)
            IDLE: begin
                if (btn_edge[B_ENTER] && !mode_block) begin
                    state_d = EDIT;
                    idx_d   = '0;
                    edit_d  = load_val;
                end
            end
            EDIT: begin
                if (mode_block || btn_edge[B_ABORT]) begin
                    state_d = IDLE;
                end else if (btn_edge[B_NEXT]) begin
                    state_d = LOAD;
                end else if (btn_edge[B_INC]) begin
                    edit_d = (edit_q >= edit_max) ? 4'd0 : (edit_q + 4'd1);
                end
            end
            LOAD: begin
                if (mode_block) begin
                    state_d = IDLE;
                end else begin
                    bus.set = NUM_DIGITS'(1) << idx_q;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (mode_block) begin
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    edit_d  = load_val;
                    state_d = EDIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, digit index, edit register and button history flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            edit_q     <= '0;
            btn_curr_q <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            edit_q     <= edit_d;
            btn_curr_q <= btn_curr_d;
            btn_prev_q <= btn_prev_d;
        end
    end

endmodule

// File: tb/tb_time_set_writer.sv
// Bench for the time-set writer. A press-level model tracks the session
// (digit under edit, edit value, expected loads) and every observed load
// strobe is compared against it, along with busy/edit_digit/value snapshots.
module tb_time_set_writer;

    localparam int ND = 4;
    localparam int B_ENTER = 0;
    localparam int B_INC   = 1;
    localparam int B_NEXT  = 2;
    localparam int B_ABORT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic          b_enter, b_inc, b_next, b_abort;
    logic [ND-1:0] edit_digit;
    logic          busy;
    logic          done;
    logic [15:0]   cur;
    logic [3:0]    held;

    time_set_writer_if #(.NUM_DIGITS(ND)) bus ();

    assign bus.cur_digit = cur;

    time_set_writer #(
        .NUM_DIGITS(ND),
        .MAX_UNITS (9),
        .MAX_TENS  (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sel_Stopwatch_Watch(sel),
        .btn_enter          (b_enter),
        .btn_inc            (b_inc),
        .btn_next           (b_next),
        .btn_abort          (b_abort),
        .bus                (bus),
        .edit_digit         (edit_digit),
        .busy               (busy),
        .done               (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_press_cyc = 0;

    // Cycle counter used for latency measurements
    always @(posedge clk) cyc++;

    typedef struct {
        int idx;
        int val;
        int cyc;
    } strobe_t;

    strobe_t obs_q[$];
    int      done_cnt = 0;
    int      last_done_cyc = -1;

    // Reference session state
    int m_active = 0;
    int m_idx = 0;
    int m_edit = 0;
    int exp_idx[$];
    int exp_val[$];
    int exp_done = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample bus outputs on the falling edge and record every load strobe
    always @(negedge clk) begin
        strobe_t s;
        if (!reset) begin
            checkOutput("set_onehot", 32'($countones(bus.set) <= 1), 32'd1);
            checkOutput("legal_zero", 32'(bus.legal), 32'd0);
            if (bus.set != '0) begin
                s.idx = 0;
                for (int i = 0; i < ND; i++) begin
                    if (bus.set[i]) s.idx = i;
                end
                s.val = int'(bus.value);
                s.cyc = cyc;
                obs_q.push_back(s);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    function automatic int dmax(input int i);
        return (i % 2 == 1) ? 5 : 9;
    endfunction

    function automatic int clampv(input int i);
        int v;
        v = int'((cur >> (4 * i)) & 16'hF);
        return (v > dmax(i)) ? 0 : v;
    endfunction

    // Press-level model of what the operator's press should do
    task automatic modelPress(input logic [3:0] mask);
        if (sel) begin
            m_active = 0;
        end else if (!m_active) begin
            if (mask[B_ENTER]) begin
                m_active = 1;
                m_idx = 0;
                m_edit = clampv(0);
            end
        end else if (mask[B_ABORT]) begin
            m_active = 0;
        end else if (mask[B_NEXT]) begin
            exp_idx.push_back(m_idx);
            exp_val.push_back(m_edit);
            if (m_idx == ND - 1) begin
                m_active = 0;
                exp_done++;
            end else begin
                m_idx++;
                m_edit = clampv(m_idx);
            end
        end else if (mask[B_INC]) begin
            m_edit = (m_edit == dmax(m_idx)) ? 0 : m_edit + 1;
        end
    endtask

    task automatic driveButtons(input logic [3:0] v);
        b_enter = v[B_ENTER];
        b_inc   = v[B_INC];
        b_next  = v[B_NEXT];
        b_abort = v[B_ABORT];
    endtask

    // Press a button combination for two cycles, release, let the FSM settle, check
    task automatic applyStimulus(input logic [3:0] mask);
        @(posedge clk);
        #1;
        last_press_cyc = cyc;
        driveButtons(mask | held);
        modelPress(mask);
        @(posedge clk);
        @(posedge clk);
        #1;
        if (mask[B_ABORT]) checkOutput("abort_busy", 32'(busy), 32'd0);
        driveButtons(held);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("edit_digit", 32'(edit_digit), m_active ? (32'd1 << m_idx) : 32'd0);
        if (m_active) checkOutput("edit_value", 32'(bus.value), 32'(m_edit));
    endtask

    task automatic setMode(input logic v);
        @(posedge clk);
        #1;
        sel = v;
        if (v) m_active = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mode_busy", 32'(busy), 32'(m_active));
    endtask

    task automatic doReset();
        #1;
        reset = 1'b1;
        m_active = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_value", 32'(bus.value), 32'd0);
        checkOutput("rst_set", 32'(bus.set), 32'd0);
        checkOutput("rst_legal", 32'(bus.legal), 32'd0);
        checkOutput("rst_edit_digit", 32'(edit_digit), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Compare the recorded strobes with the model's expected loads
    task automatic sessionCheck(input string tag);
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, 32'(obs_q.size()), 32'(exp_idx.size()));
        n = (obs_q.size() < exp_idx.size()) ? obs_q.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_idx"}, 32'(obs_q[i].idx), 32'(exp_idx[i]));
            checkOutput({tag, "_val"}, 32'(obs_q[i].val), 32'(exp_val[i]));
        end
        checkOutput({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        obs_q.delete();
        exp_idx.delete();
        exp_val.delete();
    endtask

    // Hard bound on simulation time
    initial begin
        #10000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed steps followed by randomized sessions
    initial begin
        int ninc;
        reset = 1'b1;
        sel = 1'b0;
        cur = 16'h0000;
        held = 4'b0000;
        driveButtons(4'b0000);
        $display("[TB] reset and full four-digit load");
        doReset();

        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_NEXT);
        checkOutput("latency", (obs_q.size() > 0) ? 32'(obs_q[0].cyc - last_press_cyc) : 32'hFFFF_FFFF, 32'd2);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_NEXT);
        checkOutput("done_timing", (obs_q.size() == 4) ? 32'(last_done_cyc - obs_q[3].cyc) : 32'hFFFF_FFFF, 32'd1);
        sessionCheck("all_zero");

        $display("[TB] tens digit wrap");
        cur = 16'h0040;
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_NEXT);
        repeat (3) applyStimulus(4'b0001 << B_INC);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_ABORT);
        sessionCheck("tens_wrap");

        $display("[TB] illegal live value clamps to zero");
        cur = 16'h000C;
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_ABORT);
        sessionCheck("clamp");

        $display("[TB] abort during digit 2");
        cur = 16'h3123;
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_INC);
        applyStimulus(4'b0001 << B_ABORT);
        sessionCheck("abort");

        $display("[TB] stopwatch mode blocks and aborts");
        setMode(1'b1);
        applyStimulus(4'b0001 << B_ENTER);
        setMode(1'b0);
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_INC);
        setMode(1'b1);
        setMode(1'b0);
        sessionCheck("mode");

        $display("[TB] mode change during load suppresses strobe");
        cur = 16'h0005;
        applyStimulus(4'b0001 << B_ENTER);
        @(posedge clk);
        #1;
        driveButtons(4'b0001 << B_NEXT);
        @(posedge clk);
        @(posedge clk);
        #1;
        sel = 1'b1;
        m_active = 0;
        driveButtons(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("load_mode_busy", 32'(busy), 32'd0);
        sel = 1'b0;
        sessionCheck("load_mode");

        $display("[TB] simultaneous inc and next");
        cur = 16'h0007;
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus((4'b0001 << B_INC) | (4'b0001 << B_NEXT));
        applyStimulus(4'b0001 << B_ABORT);
        sessionCheck("inc_next");

        $display("[TB] inc held across reset release");
        cur = 16'h0002;
        held = 4'b0001 << B_INC;
        driveButtons(held);
        doReset();
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_NEXT);
        applyStimulus(4'b0001 << B_ABORT);
        held = 4'b0000;
        driveButtons(held);
        sessionCheck("held_inc");

        $display("[TB] reset mid-session");
        applyStimulus(4'b0001 << B_ENTER);
        applyStimulus(4'b0001 << B_INC);
        doReset();
        sessionCheck("mid_reset");

        $display("[TB] randomized sessions");
        for (int s = 0; s < 20; s++) begin
            cur = 16'($urandom);
            applyStimulus(4'b0001 << B_ENTER);
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(0, 9) == 0) begin
                    applyStimulus(4'b0001 << B_ABORT);
                    break;
                end
                ninc = $urandom_range(0, 12);
                for (int k = 0; k < ninc; k++) applyStimulus(4'b0001 << B_INC);
                applyStimulus(4'b0001 << B_NEXT);
            end
            sessionCheck("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
